// File: rtl/note_spawner_if.sv
// Note hand-off bus between the note spawner and the note-scroll stage.
// A note transfers on any rising clk where note_valid && note_ready; while
// note_valid is high and note_ready low, note_lanes/note_beat hold steady.
interface note_spawner_if #(
    parameter int NUM_LANES = 5
);
    logic                 note_valid;
    logic                 note_ready;
    logic [NUM_LANES-1:0] note_lanes;
    logic [15:0]          note_beat;

    modport master (
        output note_valid,
        output note_lanes,
        output note_beat,
        input  note_ready
    );

    modport slave (
        input  note_valid,
        input  note_lanes,
        input  note_beat,
        output note_ready
    );
endinterface

// File: rtl/note_spawner.sv
// Beat timer plus random note spawner feeding a small note FIFO.
// Optional chords (two-hot lane masks) are enabled with macro NOTE_SPAWNER_CHORD_EN.
module note_spawner #(
    parameter int NUM_LANES  = 5,
    parameter int BEAT_TICKS = 12500000,
    parameter int CNT_W      = 24,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    input  logic [3:0]      density,
    input  logic [15:0]     rnd,
    output logic            beat_pulse,
    output logic [7:0]      overflow_cnt,
    note_spawner_if.master  note
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int ENT_W = 16 + NUM_LANES;

    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [15:0]          beat_idx_q, beat_idx_d;
    logic                 beat_pulse_q, beat_pulse_d;
    logic [PTR_W:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]       rd_ptr_q, rd_ptr_d;
    logic [7:0]           ovf_q, ovf_d;
    logic [ENT_W-1:0]     mem_q [FIFO_DEPTH];

    logic                 beat, spawn, chord;
    logic                 empty, full, pop, push_req, push;
    logic [PTR_W:0]       fill;
    logic [3:0]           lane, lane2;
    logic [NUM_LANES-1:0] lanes_mask;
    logic [ENT_W-1:0]     head;
    logic                 unused_rnd;

    assign unused_rnd = ^rnd;

    assign beat     = enable && (cnt_q == CNT_W'(BEAT_TICKS - 1));
    assign spawn    = rnd[15:12] < density;
    assign fill     = wr_ptr_q - rd_ptr_q;
    assign empty    = (fill == '0);
    assign full     = (fill == (PTR_W+1)'(FIFO_DEPTH));
    assign pop      = !empty && note.note_ready;
    assign push_req = beat && spawn;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push     = push_req && (!full || pop);

    always_comb begin
        lane  = ({1'b0, rnd[2:0]} < 4'(NUM_LANES)) ? {1'b0, rnd[2:0]}
                                                   : {1'b0, rnd[2:0]} - 4'(NUM_LANES);
`ifdef NOTE_SPAWNER_CHORD_EN
        chord = spawn && rnd[11] && (density >= 4'd8);
        lane2 = (lane + 4'd1 + ({2'b00, rnd[4:3]} % 4'(NUM_LANES - 1))) % 4'(NUM_LANES);
`else
        chord = 1'b0;
        lane2 = lane;
`endif
        lanes_mask = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            lanes_mask[i] = (lane == 4'(i)) || (chord && (lane2 == 4'(i)));
        end
    end

    always_comb begin
        cnt_d        = cnt_q;
        beat_idx_d   = beat_idx_q;
        beat_pulse_d = beat;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        ovf_d        = ovf_q;
        if (enable) begin
            cnt_d = beat ? '0 : cnt_q + 1'b1;
        end
        if (beat) begin
            beat_idx_d = beat_idx_q + 16'd1;
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_req && !push && (ovf_q != 8'hFF)) begin
            ovf_d = ovf_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            beat_idx_q   <= '0;
            beat_pulse_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            ovf_q        <= '0;
        end else begin
            cnt_q        <= cnt_d;
            beat_idx_q   <= beat_idx_d;
            beat_pulse_q <= beat_pulse_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            ovf_q        <= ovf_d;
        end
    end

    // Storage needs no reset: the pointers alone define what is queued.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= {beat_idx_q, lanes_mask};
        end
    end

    assign head            = mem_q[rd_ptr_q[PTR_W-1:0]];
    assign beat_pulse      = beat_pulse_q;
    assign overflow_cnt    = ovf_q;
    assign note.note_valid = !empty;
    assign note.note_lanes = empty ? '0 : head[NUM_LANES-1:0];
    assign note.note_beat  = empty ? '0 : head[ENT_W-1:NUM_LANES];
endmodule

// File: tb/tb_note_spawner.sv
// Directed bench for note_spawner with BEAT_TICKS=4, NUM_LANES=5, FIFO_DEPTH=4.
module tb_note_spawner;
    logic        clk;
    logic        rst;
    logic        enable;
    logic [3:0]  density;
    logic [15:0] rnd;
    logic        beat_pulse;
    logic [7:0]  overflow_cnt;
    int          n_checks;
    int          n_fail;

    note_spawner_if #(.NUM_LANES(5)) nif ();

    note_spawner #(
        .NUM_LANES (5),
        .BEAT_TICKS(4),
        .CNT_W     (24),
        .FIFO_DEPTH(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .density     (density),
        .rnd         (rnd),
        .beat_pulse  (beat_pulse),
        .overflow_cnt(overflow_cnt),
        .note        (nif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1; enable = 1'b0; density = 4'd0; rnd = 16'h0; nif.note_ready = 1'b0;
        step(2);
        chk("rst_beat_pulse", 32'(beat_pulse), 0);
        chk("rst_valid", 32'(nif.note_valid), 0);
        chk("rst_lanes", 32'(nif.note_lanes), 0);
        chk("rst_beat", 32'(nif.note_beat), 0);
        chk("rst_overflow", 32'(overflow_cnt), 0);

        // 1. basic beat
        rst = 1'b0; enable = 1'b1; density = 4'd15; rnd = 16'h0003; nif.note_ready = 1'b1;
        step(3);
        chk("t1_no_early_pulse", 32'(beat_pulse), 0);
        step(1);
        chk("t1_pulse0", 32'(beat_pulse), 1);
        chk("t1_valid0", 32'(nif.note_valid), 1);
        chk("t1_lanes0", 32'(nif.note_lanes), 32'h08);
        chk("t1_beat0", 32'(nif.note_beat), 0);
        step(1);
        chk("t1_pulse_off", 32'(beat_pulse), 0);
        chk("t1_popped", 32'(nif.note_valid), 0);
        step(3);
        chk("t1_pulse1", 32'(beat_pulse), 1);
        chk("t1_lanes1", 32'(nif.note_lanes), 32'h08);
        chk("t1_beat1", 32'(nif.note_beat), 1);

        // 2. density gating
        density = 4'd0;
        for (int i = 0; i < 10; i++) begin
            step(4);
            chk("t2_d0_valid", 32'(nif.note_valid), 0);
            chk("t2_d0_pulse", 32'(beat_pulse), 1);
        end
        density = 4'd4; rnd = 16'h3007;
        step(4);
        chk("t2_d4_valid", 32'(nif.note_valid), 1);
        chk("t2_d4_lanes", 32'(nif.note_lanes), 32'h04);
        chk("t2_d4_beat", 32'(nif.note_beat), 12);
        rnd = 16'h4000;
        step(4);
        chk("t2_nospawn", 32'(nif.note_valid), 0);
        chk("t2_nospawn_pulse", 32'(beat_pulse), 1);

        // 3. backpressure and overflow, from a fresh reset
        rst = 1'b1;
        step(1);
        chk("t3_rst_valid", 32'(nif.note_valid), 0);
        rst = 1'b0; nif.note_ready = 1'b0; density = 4'd15; rnd = 16'h0003;
        for (int k = 1; k <= 6; k++) begin
            step(4);
            chk("t3_pulse", 32'(beat_pulse), 1);
            chk("t3_valid", 32'(nif.note_valid), 1);
            chk("t3_head_stable", 32'(nif.note_beat), 0);
            chk("t3_overflow", 32'(overflow_cnt), (k > 4) ? 32'(k - 4) : 0);
        end
        nif.note_ready = 1'b1; density = 4'd0;
        for (int k = 0; k < 4; k++) begin
            chk("t3_order", 32'(nif.note_beat), 32'(k));
            chk("t3_order_lanes", 32'(nif.note_lanes), 32'h08);
            step(1);
        end
        chk("t3_drained_valid", 32'(nif.note_valid), 0);
        chk("t3_drained_lanes", 32'(nif.note_lanes), 0);
        chk("t3_drained_beat", 32'(nif.note_beat), 0);
        chk("t3_ovf_hold", 32'(overflow_cnt), 2);

        // 4. full FIFO with a pop in the push cycle
        nif.note_ready = 1'b0; density = 4'd15;
        step(16);
        chk("t4_full_head", 32'(nif.note_beat), 7);
        chk("t4_full_ovf", 32'(overflow_cnt), 2);
        step(3);
        nif.note_ready = 1'b1;
        step(1);
        chk("t4_pulse", 32'(beat_pulse), 1);
        chk("t4_ovf_same", 32'(overflow_cnt), 2);
        chk("t4_head8", 32'(nif.note_beat), 8);
        density = 4'd0;
        for (int k = 9; k <= 11; k++) begin
            step(1);
            chk("t4_order", 32'(nif.note_beat), 32'(k));
        end
        step(1);
        chk("t4_empty", 32'(nif.note_valid), 0);

        // 5. enable hold and mid-operation reset
        step(2);
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("t5_hold_no_pulse", 32'(beat_pulse), 0);
        end
        enable = 1'b1; density = 4'd15; nif.note_ready = 1'b0;
        step(1);
        chk("t5_resume_cnt3", 32'(beat_pulse), 0);
        step(1);
        chk("t5_resume_pulse", 32'(beat_pulse), 1);
        chk("t5_resume_valid", 32'(nif.note_valid), 1);
        chk("t5_beat_idx_held", 32'(nif.note_beat), 13);
        step(8);
        chk("t5_q3_head", 32'(nif.note_beat), 13);
        chk("t5_q3_ovf", 32'(overflow_cnt), 2);
        rst = 1'b1;
        step(1);
        chk("t5_rst_valid", 32'(nif.note_valid), 0);
        chk("t5_rst_ovf", 32'(overflow_cnt), 0);
        chk("t5_rst_pulse", 32'(beat_pulse), 0);
        chk("t5_rst_lanes", 32'(nif.note_lanes), 0);
        rst = 1'b0; density = 4'd0; nif.note_ready = 1'b1;
        step(4);
        chk("t5_post_pulse", 32'(beat_pulse), 1);
        chk("t5_post_empty", 32'(nif.note_valid), 0);

        // 6. chords; only the rnd value in the last beat cycle matters
        density = 4'd15; rnd = 16'h0808;
        step(1);
        rnd = 16'hF000;
        step(2);
        rnd = 16'h0808;
        step(1);
        chk("t6_pulse", 32'(beat_pulse), 1);
        chk("t6_valid", 32'(nif.note_valid), 1);
`ifdef NOTE_SPAWNER_CHORD_EN
        chk("t6_chord_lanes", 32'(nif.note_lanes), 32'h05);
`else
        chk("t6_single_lanes", 32'(nif.note_lanes), 32'h01);
`endif
        chk("t6_beat", 32'(nif.note_beat), 1);
        step(3);
        rnd = 16'hF000;
        step(1);
        chk("t6_late_nospawn", 32'(nif.note_valid), 0);
        density = 4'd7; rnd = 16'h0808;
        step(4);
        chk("t6_lowdens_lanes", 32'(nif.note_lanes), 32'h01);
        chk("t6_lowdens_beat", 32'(nif.note_beat), 3);
        density = 4'd15; rnd = 16'h081E;
        step(4);
`ifdef NOTE_SPAWNER_CHORD_EN
        chk("t6_chord_wrap", 32'(nif.note_lanes), 32'h03);
`else
        chk("t6_single_wrap", 32'(nif.note_lanes), 32'h02);
`endif
        chk("t6_wrap_beat", 32'(nif.note_beat), 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
